// File: rtl/fp_mul_pipe_param.sv
// fp_mul_pipe_param
//   Three-stage pipelined floating-point multiplier, generic in exponent and
//   mantissa width. It has valid/ready flow control, a sideband tag, and
//   round-to-nearest-even. Overflow saturates to infinity, and the multiplier
//   reports exception flags. Subnormal inputs and results flush to zero.
//
//   Stages:
//     S1  unpack / classify operands
//     S2  multiply mantissas, add exponents, resolve special operands
//     S3  normalise, round, detect range errors, pack (this is the output register)
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_a, in_b          operands {sign, exp, man}
//   in_tag              sideband tag carried with the pair
//   in_valid/in_ready   input handshake
//   out_z               product
//   out_tag             tag belonging to out_z
//   out_flags           {invalid, overflow, underflow, inexact}
//   out_valid/out_ready output handshake
module fp_mul_pipe_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic [TAG_W-1:0]       in_tag,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [EXP_W+MAN_W:0]   out_z,
  output logic [TAG_W-1:0]       out_tag,
  output logic [3:0]             out_flags,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int MW     = MAN_W + 1;          // mantissa with hidden bit
  localparam int PW     = 2 * MW;             // full product width
  localparam int XW     = EXP_W + 2;          // signed working exponent
  localparam int STAGES = 3;

  localparam logic signed [XW-1:0] BIAS    = XW'((1 << (EXP_W-1)) - 1);
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]         QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic             sign;
    logic             a_nan, a_inf, a_zero;
    logic             b_nan, b_inf, b_zero;
    logic [EXP_W-1:0] ea, eb;
    logic [MW-1:0]    ma, mb;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic                 sign;
    logic                 special;     // result already final, skip rounding
    logic [W-1:0]         spec_z;
    logic [3:0]           spec_flags;
    logic signed [XW-1:0] exp;
    logic [PW-1:0]        prod;
    logic [TAG_W-1:0]     tag;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  logic            load1, load2, load3;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;
  logic [W-1:0]    z3;
  logic [3:0]      f3;

  // A stage accepts new data when it is empty or when its occupant moves on
  // this cycle. This lets bubbles collapse under backpressure.
  assign load3     = !vld_pipe[3] || out_ready;
  assign load2     = !vld_pipe[2] || load3;
  assign load1     = !vld_pipe[1] || load2;
  assign in_ready  = load1;
  assign out_valid = vld_pipe[3];

  // ---------------- S1: unpack / classify ----------------
  always_comb begin
    s1_d        = '0;
    s1_d.sign   = in_a[W-1] ^ in_b[W-1];
    s1_d.ea     = in_a[W-2 -: EXP_W];
    s1_d.eb     = in_b[W-2 -: EXP_W];
    s1_d.a_nan  = (&s1_d.ea) &&  (|in_a[MAN_W-1:0]);
    s1_d.a_inf  = (&s1_d.ea) && !(|in_a[MAN_W-1:0]);
    s1_d.a_zero = ~|s1_d.ea;          // subnormals count as zero
    s1_d.b_nan  = (&s1_d.eb) &&  (|in_b[MAN_W-1:0]);
    s1_d.b_inf  = (&s1_d.eb) && !(|in_b[MAN_W-1:0]);
    s1_d.b_zero = ~|s1_d.eb;
    s1_d.ma     = {1'b1, in_a[MAN_W-1:0]};
    s1_d.mb     = {1'b1, in_b[MAN_W-1:0]};
    s1_d.tag    = in_tag;
  end

  // ---------------- S2: multiply / specials ----------------
  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    s2_d.tag  = s1_q.tag;
    s2_d.prod = PW'(s1_q.ma) * PW'(s1_q.mb);
    s2_d.exp  = $signed({2'b00, s1_q.ea}) + $signed({2'b00, s1_q.eb}) - BIAS;
    if (s1_q.a_nan || s1_q.b_nan ||
        (s1_q.a_inf && s1_q.b_zero) || (s1_q.b_inf && s1_q.a_zero)) begin
      s2_d.special    = 1'b1;
      s2_d.spec_z     = QNAN;
      s2_d.spec_flags = 4'b1000;
    end else if (s1_q.a_inf || s1_q.b_inf) begin
      s2_d.special = 1'b1;
      s2_d.spec_z  = {s1_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s1_q.a_zero || s1_q.b_zero) begin
      s2_d.special = 1'b1;
      s2_d.spec_z  = {s1_q.sign, {(W-1){1'b0}}};
    end
  end

  // ---------------- S3: normalise / round / pack ----------------
  // The product of two [1,2) mantissas lies in [1,4). Only the fraction
  // below the leading one is kept. A carry out of the rounded fraction means
  // the mantissa wrapped to 1.000..0, so it only bumps the exponent.
  logic                 msb;
  logic [PW-2:0]        frac_all;
  logic [MAN_W-1:0]     frac;
  logic                 guard, sticky, inc;
  logic [MAN_W:0]       frac_r;
  logic signed [XW-1:0] e_fin;

  always_comb begin
    msb      = s2_q.prod[PW-1];
    frac_all = msb ? s2_q.prod[PW-2:0] : {s2_q.prod[PW-3:0], 1'b0};
    frac     = frac_all[PW-2 -: MAN_W];
    guard    = frac_all[MAN_W];
    sticky   = |frac_all[MAN_W-1:0];
    inc      = guard && (sticky || frac[0]);
    frac_r   = {1'b0, frac} + (MAN_W+1)'(inc);
    e_fin    = s2_q.exp + XW'(msb) + XW'(frac_r[MAN_W]);
    z3       = '0;
    f3       = '0;
    if (s2_q.special) begin
      z3 = s2_q.spec_z;
      f3 = s2_q.spec_flags;
    end else if (e_fin >= EXP_MAX) begin
      z3 = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      f3 = 4'b0101;
    end else if (e_fin <= 0) begin
      z3 = {s2_q.sign, {(W-1){1'b0}}};
      f3 = 4'b0011;
    end else begin
      z3 = {s2_q.sign, e_fin[EXP_W-1:0], frac_r[MAN_W-1:0]};
      f3 = {3'b000, guard || sticky};
    end
  end

  // ---------------- state ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      out_z     <= '0;
      out_tag   <= '0;
      out_flags <= '0;
    end else begin
      if (load1) vld_pipe[1] <= in_valid;
      if (load2) vld_pipe[2] <= vld_pipe[1];
      if (load3) vld_pipe[3] <= vld_pipe[2];
      if (load3 && vld_pipe[2]) begin
        out_z     <= z3;
        out_tag   <= s2_q.tag;
        out_flags <= f3;
      end
    end
  end

  // Datapath registers only move with a valid occupant. Their contents are
  // meaningless while the matching valid bit is low, so they need no reset.
  always_ff @(posedge clk) begin
    if (load1 && in_valid)    s1_q <= s1_d;
    if (load2 && vld_pipe[1]) s2_q <= s2_d;
  end

endmodule

// File: tb/tb_fp_mul_pipe_param.sv
// Directed bench for fp_mul_pipe_param with its default bf16 shape. Inputs are
// driven on the falling edge and outputs are sampled just after it.
module tb_fp_mul_pipe_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_a, in_b, out_z;
  logic [3:0]  in_tag, out_tag, out_flags;
  logic        in_valid, in_ready, out_valid, out_ready;

  int n_chk = 0;
  int n_err = 0;
  int sent, got, cyc, emitted;

  fp_mul_pipe_param #(.EXP_W(8), .MAN_W(7), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_z(out_z), .out_tag(out_tag), .out_flags(out_flags),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  // Single op into an idle pipe. Called on a falling edge and returns on the
  // falling edge where the result is visible.
  task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] tg, input logic [15:0] ez, input logic [3:0] ef);
    int lat;
    in_a = a; in_b = b; in_tag = tg; in_valid = 1'b1; out_ready = 1'b1;
    #1 check({nm, "_rdy"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    #1;
    check({nm, "_lat"}, lat, 3);
    check({nm, "_z"}, out_z, ez);
    check({nm, "_tag"}, out_tag, tg);
    check({nm, "_flags"}, out_flags, ef);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_tag = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_z", out_z, 0);
    check("rst_tag", out_tag, 0);
    check("rst_flags", out_flags, 0);
    rst_n = 1'b1;
    #1 check("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // basic, rounding, sign
    run_op("one",   16'h3F80, 16'h3F80, 4'd3, 16'h3F80, 4'b0000);
    run_op("tie",   16'h3F81, 16'h3FC0, 4'd1, 16'h3FC2, 4'b0001);
    run_op("exact", 16'h3FC0, 16'h3FC0, 4'd2, 16'h4010, 4'b0000);
    run_op("neg",   16'h4040, 16'hC000, 4'd4, 16'hC0C0, 4'b0000);
    // specials
    run_op("infz",  16'h7F80, 16'h0000, 4'd5, 16'h7FC0, 4'b1000);
    run_op("ninf",  16'hFF80, 16'h4000, 4'd6, 16'hFF80, 4'b0000);
    run_op("nan",   16'h7FC1, 16'h3F80, 4'd7, 16'h7FC0, 4'b1000);
    // range boundaries
    run_op("ovf",   16'h7F7F, 16'h4000, 4'd8, 16'h7F80, 4'b0101);
    run_op("unf",   16'h0080, 16'h3E80, 4'd9, 16'h0000, 4'b0011);
    run_op("sub",   16'h8001, 16'h3F80, 4'd10, 16'h8000, 4'b0000);

    // Stream of 8 ops with out_ready held low in cycles 2..7.
    // Op i is 1.5 * 2^i, which is exact and has tag i.
    @(negedge clk);
    sent = 0; got = 0; cyc = 0;
    while (got < 8 && cyc < 60) begin
      out_ready = !(cyc >= 2 && cyc <= 7);
      in_valid  = (sent < 8);
      in_a      = 16'h3FC0;
      in_b      = 16'h3F80 + 16'(sent << 7);
      in_tag    = 4'(sent);
      #1;
      if (cyc == 3) check("s_in_ready_full", in_ready, 0);
      if (out_valid) begin
        check("s_z", out_z, 16'h3FC0 + 16'(got << 7));
        check("s_tag", out_tag, got);
        check("s_flags", out_flags, 0);
        if (out_ready) got++;
      end
      if (in_valid && in_ready) sent++;
      if (cyc == 7) check("s_sent_stall", sent, 3);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("s_count", got, 8);

    // Reset with three ops in flight.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      in_a = 16'h3F80; in_b = 16'h4000; in_tag = 4'(12 + i); in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1 check("r_full", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("r_valid", out_valid, 0);
    check("r_z", out_z, 0);
    @(negedge clk);
    rst_n = 1'b1;
    emitted = 0;
    repeat (8) begin
      @(negedge clk);
      #1 if (out_valid) emitted++;
    end
    check("r_emitted", emitted, 0);
    @(negedge clk);
    run_op("r_next", 16'h4000, 16'h4000, 4'hA, 16'h4080, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
